regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single write port of the 32x64 register file between NREQ writeback
//  sources (e.g. ALU, load unit, mul/div).
//  - Each source owns a 1-entry holding buffer; a round-robin arbiter drains one
//    buffer per cycle into a registered write port.
//  - Flags read-after-write hazards for the two read ports while a write is buffered
//    but not yet committed.
//  - Sits between execute/memory writeback and the register file.
// PARAMETERS
//  NREQ       2   number of writeback requesters (2..4)
//  AW         5   register address width (32 registers)
//  DW         64  register data width
//  ZERO_DROP  1   1: writes to register 0 are consumed but never drive rf_wen
// PORTS
//  clk        in   1         rising-edge clock
//  reset      in   1         synchronous, active-high reset
//  req_valid  in   NREQ      requester i presents a write
//  req_ready  out  NREQ      requester i buffer can accept (valid&ready = transfer)
//  req_addr   in   NREQ*AW   dest register, slice [i*AW +: AW]
//  req_data   in   NREQ*DW   write data, slice [i*DW +: DW]
//  rf_wen     out  1         register-file write enable (registered)
//  rf_waddr   out  AW        register-file write address (registered)
//  rf_wdata   out  DW        register-file write data (registered)
//  rsrc1      in   AW        read-port-1 address being decoded
//  rsrc2      in   AW        read-port-2 address being decoded
//  hz1        out  1         rsrc1 matches a buffered or in-flight write
//  hz2        out  1         rsrc2 matches a buffered or in-flight write
//  idle       out  1         all buffers empty and rf_wen low
// BEHAVIOUR
//  - Reset (clk edge with reset=1): buffers empty, rr pointer=0, rf_wen=0,
//    rf_waddr=0, rf_wdata=0. While reset=1: req_ready=0, hz1=hz2=0, idle=1.
//  - Buffer i: full/addr/data. Loads on req_valid[i]&req_ready[i].
//  - req_ready[i] = !full[i] | grant[i] (combinational): accepts a new entry in the
//    cycle the old one drains. One transfer per requester per cycle.
//  - Arbiter: combinational grant over full buffers. Search starts at rr pointer,
//    increasing index, wraps NREQ-1 -> 0. At most one grant per cycle.
//  - rr pointer <= granted index + 1 (mod NREQ) on a grant; unchanged otherwise.
//  - Latency: accept at edge N -> earliest grant in cycle N..N+1 -> rf_wen high for
//    exactly one cycle after the grant edge. Min 2 edges from req handshake to commit.
//  - Throughput: 1 write/cycle sustained. Each requester gets >= 1 grant per NREQ
//    cycles under full load (starvation-free).
//  - Granted entry with addr==0 and ZERO_DROP=1: buffer clears, rr advances,
//    rf_wen=0 that cycle.
//  - No grant: rf_wen=0; rf_waddr/rf_wdata hold their last values.
//  - Per-requester write order is preserved. Cross-requester order to the same
//    register follows grant order; the issue stage prevents such WAW pairs.
//  - hz1 = OR over i of (full[i] & addr[i]==rsrc1), OR (rf_wen & rf_waddr==rsrc1).
//    hz2 uses rsrc2. Address 0 never flags a hazard when ZERO_DROP=1.
//  - Reset mid-operation: buffered writes are discarded and nothing is committed.
//    A transfer coincident with reset is lost.
//  - idle = !(|full) & !rf_wen.
// CONFIGURATION
//  REGFILE_WB_TRACE_EN defined:
//    - $display($time, rf_waddr, rf_wdata) on every cycle with rf_wen=1.
//    - $display on every dropped r0 write.
//    - Simulation-only error on req_valid deasserted while holding a value.
//  REGFILE_WB_TRACE_EN undefined: no display/check code; ports and timing identical.
// TESTING
//  1. Reset 3 cycles, all req_valid=0 -> req_ready=0 during reset, then all 1;
//     rf_wen=0, idle=1.
//  2. req0 (addr=5, data=0xAA) single pulse -> rf_wen=1 one cycle later with
//     waddr=5, wdata=0xAA; hz1 high while rsrc1=5 until commit clears.
//  3. req0 (addr=1, data=0x11) and req1 (addr=2, data=0x22) same cycle ->
//     commits addr1 then addr2 on consecutive cycles; rr ends at 0.
//  4. Both valid continuously for 8 cycles, distinct data -> commits alternate
//     0,1,0,1...; 1 write/cycle; no requester waits >1 cycle.
//  5. req1 addr=0, data=0xFF -> req_ready handshake completes; rf_wen stays 0;
//     hz2 with rsrc2=0 stays 0.
//  6. Both buffers full, assert reset one cycle -> no rf_wen after reset; idle=1;
//     rr=0.

Source files
------------

// File: rtl/regfile_wb_if.sv
// ----------------------------------------------------------------------------
// regfile_wb_if
// Bundles the writeback request lanes, the register-file write port and the
// read-port hazard lookup that connect to regfile_wb_arbiter.
//
// Handshake: on a rising clock edge, requester i hands over its write when
// req_valid[i] and req_ready[i] are both high. The requester holds req_valid,
// req_addr and req_data steady until that edge. req_ready may depend
// combinationally on the arbiter's grant in the same cycle.
//
// Signals
//   req_valid [NREQ]     requester i presents a write
//   req_ready [NREQ]     requester i holding buffer can accept
//   req_addr  [NREQ*AW]  destination register, lane i at [i*AW +: AW]
//   req_data  [NREQ*DW]  write data, lane i at [i*DW +: DW]
//   rf_wen / rf_waddr / rf_wdata  registered register-file write port
//   rsrc1 / rsrc2        read-port addresses being decoded
//   hz1 / hz2            read address matches a pending or in-flight write
//   idle                 no buffered write and no write in flight
//   dbg_rr               round-robin pointer (debug visibility)
// Modports: slave = arbiter side, master = requester/register-file side.
// ----------------------------------------------------------------------------
interface regfile_wb_if #(
    parameter int NREQ = 2,
    parameter int AW   = 5,
    parameter int DW   = 64
);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               rf_wen;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [AW-1:0]      rsrc1;
    logic [AW-1:0]      rsrc2;
    logic               hz1;
    logic               hz2;
    logic               idle;
    logic [RW-1:0]      dbg_rr;

    modport slave (
        input  req_valid, req_addr, req_data, rsrc1, rsrc2,
        output req_ready, rf_wen, rf_waddr, rf_wdata, hz1, hz2, idle, dbg_rr
    );

    modport master (
        output req_valid, req_addr, req_data, rsrc1, rsrc2,
        input  req_ready, rf_wen, rf_waddr, rf_wdata, hz1, hz2, idle, dbg_rr
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single write port of the register file between NREQ writeback
// sources. Each source owns a one-entry holding buffer; a round-robin arbiter
// drains one buffer per cycle into a registered write port. Read-after-write
// hazards are flagged for two read ports while a write is buffered or in
// flight.
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   wb     regfile_wb_if.slave: request lanes, write port, hazard lookup
//
// Parameters: NREQ (2..4), AW, DW, ZERO_DROP (1: r0 writes are consumed but
// never raise rf_wen and r0 never flags a hazard).
//
// Optional build macro REGFILE_WB_TRACE_EN: simulation trace of every commit
// and dropped r0 write, plus a check that a requester does not withdraw
// req_valid while its write is still waiting. Ports and timing are identical
// with or without it.
// ----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NREQ      = 2,
    parameter int AW        = 5,
    parameter int DW        = 64,
    parameter int ZERO_DROP = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_wb_if.slave  wb
);
    localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] r_full;
    logic [AW-1:0]   r_addr [NREQ];
    logic [DW-1:0]   r_data [NREQ];
    logic [RW-1:0]   r_rr;
    logic            r_wen;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;

    logic [NREQ-1:0] w_grant;
    logic            w_gnt_any;
    logic [RW-1:0]   w_gnt_idx;
    logic            w_gnt_drop;
    logic [NREQ-1:0] w_ready;
    logic [NREQ-1:0] w_accept;
    logic            w_hz1;
    logic            w_hz2;

    // Round-robin search: first full buffer at or after r_rr, wrapping.
    always_comb begin
        logic [RW-1:0] idx;
        idx       = '0;
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = RW'((int'(r_rr) + k) % NREQ);
            if (!w_gnt_any && r_full[idx]) begin
                w_gnt_any      = 1'b1;
                w_gnt_idx      = idx;
                w_grant[idx]   = 1'b1;
            end
        end
    end

    assign w_gnt_drop = (ZERO_DROP != 0) && (r_addr[w_gnt_idx] == '0);

    // A buffer draining this cycle can be refilled in the same cycle.
    assign w_ready  = reset ? '0 : (~r_full | w_grant);
    assign w_accept = wb.req_valid & w_ready;

    // Hazard lookup against buffered entries and the write being committed.
    always_comb begin
        w_hz1 = r_wen && (r_waddr == wb.rsrc1);
        w_hz2 = r_wen && (r_waddr == wb.rsrc2);
        for (int i = 0; i < NREQ; i++) begin
            if (r_full[i] && (r_addr[i] == wb.rsrc1)) w_hz1 = 1'b1;
            if (r_full[i] && (r_addr[i] == wb.rsrc2)) w_hz2 = 1'b1;
        end
        if ((ZERO_DROP != 0) && (wb.rsrc1 == '0)) w_hz1 = 1'b0;
        if ((ZERO_DROP != 0) && (wb.rsrc2 == '0)) w_hz2 = 1'b0;
        if (reset) begin
            w_hz1 = 1'b0;
            w_hz2 = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full  <= '0;
            r_rr    <= '0;
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen <= w_gnt_any && !w_gnt_drop;
            if (w_gnt_any) begin
                r_rr <= RW'((int'(w_gnt_idx) + 1) % NREQ);
                // Dropped r0 writes leave the last committed address/data.
                if (!w_gnt_drop) begin
                    r_waddr <= r_addr[w_gnt_idx];
                    r_wdata <= r_data[w_gnt_idx];
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (w_accept[i]) begin
                    r_full[i] <= 1'b1;
                    r_addr[i] <= wb.req_addr[i*AW +: AW];
                    r_data[i] <= wb.req_data[i*DW +: DW];
                end else if (w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    assign wb.req_ready = w_ready;
    assign wb.rf_wen    = r_wen;
    assign wb.rf_waddr  = r_waddr;
    assign wb.rf_wdata  = r_wdata;
    assign wb.hz1       = w_hz1;
    assign wb.hz2       = w_hz2;
    assign wb.idle      = reset | (~(|r_full) & ~r_wen);
    assign wb.dbg_rr    = r_rr;

`ifdef REGFILE_WB_TRACE_EN
    // Requesters that presented a write last cycle without it being taken.
    logic [NREQ-1:0] r_tr_pend;

    always_ff @(posedge clk) begin
        if (r_wen) begin
            $display("%0t regfile write addr=%0d data=%h", $time, r_waddr, r_wdata);
        end
        if (!reset && w_gnt_any && w_gnt_drop) begin
            $display("%0t regfile r0 write dropped from requester %0d", $time, w_gnt_idx);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!reset && r_tr_pend[i] && !wb.req_valid[i]) begin
                $error("requester %0d withdrew req_valid while its write was waiting", i);
            end
        end
        r_tr_pend <= reset ? '0 : (wb.req_valid & ~w_ready);
    end
`else
    // Trace and protocol checking are compiled out.
`endif

endmodule
